// File: rtl/serial_adder_nb.sv
// serial_adder_nb: bit-serial add/subtract unit, one result bit per clock, LSB first.
// A single full-adder slice and a carry flop process WIDTH bits. start/busy/done
// handshake; sum, cout and signed overflow are loaded only when the last bit is
// produced, so they never show partial values.
// Optional build macro: SERIAL_ADD_SAT_EN -- when defined, an overflowing result
// saturates to the signed limit (cout/overflow still report the raw values).
// Reset is asynchronous and active-high.

module serial_adder_nb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Counter wide enough to reach WIDTH-1; at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // Operand A doubles as the partial-result register: each RUN edge consumes
    // its LSB and shifts the new sum bit into the vacated MSB, so after WIDTH
    // edges the register holds the complete result.
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
`ifdef SERIAL_ADD_SAT_EN
    // Sign of operand A, needed for the saturation direction after A has been
    // shifted out.
    logic             asign_q, asign_d;
`endif

    // Full-adder slice over the current LSBs and the carry flop.
    logic             s_bit;
    logic             carry_next;
    logic [WIDTH-1:0] opa_shift;
    logic [WIDTH-1:0] opb_shift;

    assign s_bit      = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_next = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    // Right shifts; a one-bit register has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign opa_shift = s_bit;
            assign opb_shift = 1'b0;
        end else begin : g_shift_wn
            assign opa_shift = {s_bit, opa_q[WIDTH-1:1]};
            assign opb_shift = {1'b0, opb_q[WIDTH-1:1]};
        end
    endgenerate

    // Next-state, datapath and result computation.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADD_SAT_EN
        asign_d = asign_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SAT_EN
                    asign_d = a[WIDTH-1];
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                opa_d   = opa_shift;
                opb_d   = opb_shift;
                carry_d = carry_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this final edge.
                    cout_d  = carry_next;
                    ovf_d   = carry_q ^ carry_next;
`ifdef SERIAL_ADD_SAT_EN
                    if (carry_q ^ carry_next) begin
                        sum_d = asign_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        sum_d = opa_shift;
                    end
`else
                    sum_d   = opa_shift;
`endif
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_ADD_SAT_EN
            asign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_ADD_SAT_EN
            asign_q <= asign_d;
`endif
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_nb.sv
// tb_serial_adder_nb: directed and randomized operations against an arithmetic
// reference model (integer add, signed range check for overflow).

module tb_serial_adder_nb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks = 0;
    int n_errs   = 0;

    serial_adder_nb #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on the signed/unsigned values.
    // Returns {overflow, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        longint ua, ub, ures, sa, sb, sres;
        logic   c, v;
        logic [W-1:0] s;
        ua = longint'(ma);
        ub = longint'(mb);
        sa = ma[W-1] ? ua - (longint'(1) << W) : ua;
        sb = mb[W-1] ? ub - (longint'(1) << W) : ub;
        if (msub) begin
            ures = ua - ub;
            c    = (ua >= ub);          // 1 means no borrow
            sres = sa - sb;
        end else begin
            ures = ua + ub + longint'(mcin);
            c    = (ures >= (longint'(1) << W));
            sres = sa + sb + longint'(mcin);
        end
        s = ures[W-1:0];
        v = (sres > ((longint'(1) << (W-1)) - 1)) || (sres < -(longint'(1) << (W-1)));
`ifdef SERIAL_ADD_SAT_EN
        if (v) s = (sres > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        return {v, c, s};
    endfunction

    // One complete operation. inject >= 0 raises start with junk operands on
    // that RUN cycle, which must be ignored.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input int inject);
        logic [W+1:0] exp;
        logic [W-1:0] prev_sum;
        exp      = model(ta, tb_v, tc, ts);
        @(negedge clk);
        prev_sum = sum;
        a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);                       // E0 has passed
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            check("busy_run", busy, 1'b1);
            check("done_early", done, 1'b0);
            check("sum_hold", sum, prev_sum);
            start = (i == inject);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", done, 1'b1);
        check("busy_done", busy, 1'b0);
        check("sum", sum, exp[W-1:0]);
        check("cout", cout, exp[W]);
        check("overflow", overflow, exp[W+1]);
        $display("op a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d ovf=%0d (exp %02h %0d %0d)",
                 ta, tb_v, tc, ts, sum, cout, overflow, exp[W-1:0], exp[W], exp[W+1]);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("sum_after", sum, exp[W-1:0]);
    endtask

    initial begin
        logic [W+1:0] bexp;
        int last_done;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, -1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'h05, 8'h07, 1'b1, 1'b1, -1);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, -1);
        run_op(8'h11, 8'h22, 1'b0, 1'b0, 2);     // start raised again at E3
        run_op(8'h80, 8'h80, 1'b0, 1'b0, W-1);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_sum", sum, '0);
        check("mid_rst_cout", cout, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        run_op(8'h3C, 8'h0A, 1'b1, 1'b0, -1);

        // Randomized operations.
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, W + 3)) - 2);
        end

        // Back-to-back with start held high.
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; cin = 1'b1; sub = 1'b0; start = 1'b1;
        bexp = model(8'hA5, 8'h3C, 1'b1, 1'b0);
        last_done = -1;
        for (int c = 1; c <= 4 * (W + 2) + 2; c++) begin
            @(negedge clk);
            if (done) begin
                if (last_done < 0) check("b2b_first_latency", c, W + 1);
                else               check("b2b_period", c - last_done, W + 2);
                check("b2b_sum", sum, bexp[W-1:0]);
                last_done = c;
            end else if (last_done >= 0) begin
                check("b2b_hold", sum, bexp[W-1:0]);
            end
        end
        check("b2b_seen", last_done > 0, 1'b1);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("b2b_idle", busy | done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
